// File: rtl/mac_stream_pkg.sv
// Shared types and constant helpers for the multi-lane multiply-accumulate engine.
// Widths up to MAX_ACC_WIDTH bits are supported by the clamp-value helpers.
package mac_stream_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } state_e;

    localparam int MAX_ACC_WIDTH = 64;

    // Width needed to hold the sum of all lane products without loss.
    function automatic int sum_width(input int dw, input int lanes);
        return 2 * dw + $clog2(lanes);
    endfunction

    function automatic logic [MAX_ACC_WIDTH-1:0] acc_max(input int acc_w, input bit is_signed);
        logic [MAX_ACC_WIDTH-1:0] one;
        one = MAX_ACC_WIDTH'(1);
        if (is_signed) begin
            return (one << (acc_w - 1)) - one;
        end
        return (one << acc_w) - one;
    endfunction

    // Signed minimum is returned sign-extended; callers slice the low acc_w bits.
    function automatic logic [MAX_ACC_WIDTH-1:0] acc_min(input int acc_w, input bit is_signed);
        logic [MAX_ACC_WIDTH-1:0] one;
        one = MAX_ACC_WIDTH'(1);
        if (is_signed) begin
            return ~((one << (acc_w - 1)) - one);
        end
        return '0;
    endfunction

endpackage

// File: rtl/mac_stream_lane.sv
// One lane of the engine: a registered DATA_WIDTH x DATA_WIDTH multiply.
// Operands are extended to the product width first, so one multiplier serves both signed modes.
module mac_stream_lane
    import mac_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int SIGNED     = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en_i,
    input  logic [DATA_WIDTH-1:0]     a_i,
    input  logic [DATA_WIDTH-1:0]     b_i,
    output logic [2*DATA_WIDTH-1:0]   prod_o
);

    localparam int PW = 2 * DATA_WIDTH;

    logic [PW-1:0] a_ext;
    logic [PW-1:0] b_ext;
    logic [PW-1:0] prod_d;
    logic [PW-1:0] prod_q;

    always_comb begin
        a_ext = '0;
        b_ext = '0;
        if (SIGNED != 0) begin
            a_ext = PW'($signed(a_i));
            b_ext = PW'($signed(b_i));
        end else begin
            a_ext = PW'(a_i);
            b_ext = PW'(b_i);
        end
        // Low PW bits of the product are identical for signed and unsigned once extended.
        prod_d = a_ext * b_ext;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q <= '0;
        end else if (en_i) begin
            prod_q <= prod_d;
        end
    end

    assign prod_o = prod_q;

endmodule

// File: rtl/mac_stream.sv
// Pipelined multi-lane dot-product engine: multiply (S1), lane sum (S2), saturating accumulate (S3),
// sequenced by an IDLE/ACCUM/DRAIN/HOLD controller with valid/ready input and result ports.
module mac_stream
    import mac_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int LANES      = 4,
    parameter int ACC_WIDTH  = 24,
    parameter int LEN_WIDTH  = 8,
    parameter int SIGNED     = 0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [LEN_WIDTH-1:0]        cfg_len,
    input  logic                        clr,
    output logic                        busy,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [LANES*DATA_WIDTH-1:0] a_in,
    input  logic [LANES*DATA_WIDTH-1:0] b_in,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [ACC_WIDTH-1:0]        out_data,
    output logic                        out_ovf
);

    localparam int PW        = 2 * DATA_WIDTH;
    localparam int SW        = sum_width(DATA_WIDTH, LANES);
    localparam int EW        = ((SW > ACC_WIDTH) ? SW : ACC_WIDTH) + 1;
    localparam bit IS_SIGNED = (SIGNED != 0);

    localparam logic [MAX_ACC_WIDTH-1:0] ACC_MAX_FULL = acc_max(ACC_WIDTH, IS_SIGNED);
    localparam logic [MAX_ACC_WIDTH-1:0] ACC_MIN_FULL = acc_min(ACC_WIDTH, IS_SIGNED);
    localparam logic [ACC_WIDTH-1:0]     ACC_MAX      = ACC_MAX_FULL[ACC_WIDTH-1:0];
    localparam logic [ACC_WIDTH-1:0]     ACC_MIN      = ACC_MIN_FULL[ACC_WIDTH-1:0];

    state_e                 state_q;
    logic [LEN_WIDTH-1:0]   cnt_q;
    logic                   busy_q;
    logic                   in_ready_q;
    logic                   out_valid_q;

    logic                   s1_valid_q;
    logic                   s2_valid_q;
    logic [SW-1:0]          sum_q;
    logic [SW-1:0]          sum_d;
    logic [ACC_WIDTH-1:0]   acc_q;
    logic [ACC_WIDTH-1:0]   acc_d;
    logic                   ovf_q;
    logic                   sat_d;

    logic                   accept;
    logic                   job_start;

    logic [PW-1:0]          prod     [LANES];
    logic [SW-1:0]          prod_ext [LANES];

    logic [EW-1:0]          acc_ext;
    logic [EW-1:0]          sum_ext;
    logic [EW-1:0]          max_ext;
    logic [EW-1:0]          min_ext;
    logic [EW-1:0]          total;
    logic                   over;
    logic                   under;

    // A beat offered while clr is high must not enter the pipeline.
    assign accept    = in_valid && in_ready_q && !clr;
    assign job_start = (state_q == IDLE) && start && (cfg_len != '0);

    // S1: one registered multiplier per lane, each product widened to the lane-sum width.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            mac_stream_lane #(
                .DATA_WIDTH (DATA_WIDTH),
                .SIGNED     (SIGNED)
            ) u_lane (
                .clk    (clk),
                .rst_n  (rst_n),
                .en_i   (accept),
                .a_i    (a_in[gi*DATA_WIDTH +: DATA_WIDTH]),
                .b_i    (b_in[gi*DATA_WIDTH +: DATA_WIDTH]),
                .prod_o (prod[gi])
            );

            if (IS_SIGNED) begin : g_sext
                assign prod_ext[gi] = SW'($signed(prod[gi]));
            end else begin : g_zext
                assign prod_ext[gi] = SW'(prod[gi]);
            end
        end
    endgenerate

    always_comb begin
        sum_d = '0;
        for (int i = 0; i < LANES; i++) begin
            sum_d = sum_d + prod_ext[i];
        end
    end

    // S3 adds in a width that cannot wrap, then clamps to the accumulator range.
    always_comb begin
        acc_ext = '0;
        sum_ext = '0;
        max_ext = '0;
        min_ext = '0;
        over    = 1'b0;
        under   = 1'b0;
        if (IS_SIGNED) begin
            acc_ext = EW'($signed(acc_q));
            sum_ext = EW'($signed(sum_q));
            max_ext = EW'($signed(ACC_MAX));
            min_ext = EW'($signed(ACC_MIN));
        end else begin
            acc_ext = EW'(acc_q);
            sum_ext = EW'(sum_q);
            max_ext = EW'(ACC_MAX);
            min_ext = EW'(ACC_MIN);
        end
        total = acc_ext + sum_ext;
        if (IS_SIGNED) begin
            over  = $signed(total) > $signed(max_ext);
            under = $signed(total) < $signed(min_ext);
        end else begin
            over  = total > max_ext;
        end
        sat_d = over || under;
        if (over) begin
            acc_d = ACC_MAX;
        end else if (under) begin
            acc_d = ACC_MIN;
        end else begin
            acc_d = total[ACC_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (clr) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (job_start) begin
                        state_q    <= ACCUM;
                        cnt_q      <= cfg_len;
                        busy_q     <= 1'b1;
                        in_ready_q <= 1'b1;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        cnt_q <= cnt_q - LEN_WIDTH'(1);
                        if (cnt_q == LEN_WIDTH'(1)) begin
                            state_q    <= DRAIN;
                            in_ready_q <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    // Once S1 and S2 are empty the accumulator already holds the final beat.
                    if (!s1_valid_q && !s2_valid_q) begin
                        state_q     <= HOLD;
                        out_valid_q <= 1'b1;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            sum_q      <= '0;
            acc_q      <= '0;
            ovf_q      <= 1'b0;
        end else if (clr) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            acc_q      <= '0;
            ovf_q      <= 1'b0;
        end else begin
            s1_valid_q <= accept;
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                sum_q <= sum_d;
            end
            if (job_start) begin
                acc_q <= '0;
                ovf_q <= 1'b0;
            end else if (s2_valid_q) begin
                acc_q <= acc_d;
                if (sat_d) begin
                    ovf_q <= 1'b1;
                end
            end
        end
    end

    assign busy      = busy_q;
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = acc_q;
    assign out_ovf   = ovf_q;

endmodule
